// File: rtl/shift_right_logical_32_pkg.sv
// Shared ALU constants and helpers for the logical right shifter.
// Shift-amount range detection lives here so other ALU units can reuse it.
package shift_right_logical_32_pkg;

    localparam int DATA_W  = 32'd32;
    localparam int SHAMT_W = 32'd5;

    // Any set bit above the barrel-shifter select field means the shift is >= DATA_W.
    function automatic logic is_out_of_range(input logic [DATA_W-1:0] amt);
        return |amt[DATA_W-1:SHAMT_W];
    endfunction

endpackage

// File: rtl/shift_right_logical_32_srl_stage.sv
// One stage of the log barrel shifter: passes data through or shifts it
// right by a fixed distance with zero fill, chosen by one shift-amount bit.
module srl_stage
    import shift_right_logical_32_pkg::*;
#(
    parameter int unsigned SHIFT = 32'd1
) (
    input  logic              sel,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] dout_s;

    // Select between the unshifted and the fixed-distance shifted word.
    always_comb begin
        dout_s = din;
        if (sel) begin
            dout_s = din >> SHIFT;
        end else begin
            dout_s = din;
        end
    end

    assign dout = dout_s;

endmodule

// File: rtl/shift_right_logical_32.sv
// Registered 32-bit logical right shifter; shift amounts of 32 or more give zero.
// Five barrel stages feed an overflow mask and a single output register.
module shift_right_logical_32
    import shift_right_logical_32_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] X,
    input  logic [DATA_W-1:0] Y,
    output logic [DATA_W-1:0] Z,
    output logic              out_valid
);

    logic [DATA_W-1:0] stage_s [0:SHAMT_W];
    logic [DATA_W-1:0] result_s;
    logic              out_of_range_s;
    logic [DATA_W-1:0] z_r;
    logic              valid_r;

    assign stage_s[0] = X;

    genvar g;
    generate
        for (g = 0; g < SHAMT_W; g++) begin : g_stage
            srl_stage #(
                .SHIFT (32'd1 << g)
            ) u_stage (
                .sel  (Y[g]),
                .din  (stage_s[g]),
                .dout (stage_s[g+1])
            );
        end
    endgenerate

    assign out_of_range_s = is_out_of_range(Y);

    // Force zero when the full unsigned shift amount reaches the word width.
    always_comb begin
        result_s = stage_s[SHAMT_W];
        if (out_of_range_s) begin
            result_s = {DATA_W{1'b0}};
        end else begin
            result_s = stage_s[SHAMT_W];
        end
    end

    // Output register: Z holds across idle cycles, valid tracks the previous accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            z_r     <= {DATA_W{1'b0}};
            valid_r <= 1'b0;
        end else if (in_valid) begin
            z_r     <= result_s;
            valid_r <= 1'b1;
        end else begin
            z_r     <= z_r;
            valid_r <= 1'b0;
        end
    end

    assign Z         = z_r;
    assign out_valid = valid_r;

endmodule

// File: tb/tb_shift_right_logical_32.sv
// Directed and random checks of the registered logical right shifter,
// with expected results queued at drive time and popped when output appears.
module tb_shift_right_logical_32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] X = 32'h0;
    logic [31:0] Y = 32'h0;
    logic [31:0] Z;
    logic        out_valid;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb_q [$];
    logic [31:0] hold_z = 32'h0;
    logic        exp_v = 1'b0;

    shift_right_logical_32 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .X         (X),
        .Y         (Y),
        .Z         (Z),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_srl(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] r;
        r = x;
        if (y > 32'd31) begin
            r = 32'h0;
        end else begin
            for (int k = 0; k < 32; k++) begin
                if (k < 32 - int'(y)) r[k] = x[k + int'(y)];
                else                  r[k] = 1'b0;
            end
        end
        return r;
    endfunction

    task automatic step(input logic [31:0] x, input logic [31:0] y, input logic v,
                        input logic r, input logic [31:0] exp, input string tag);
        X = x;
        Y = y;
        in_valid = v;
        rst = r;
        if (v && !r) sb_q.push_back(exp);
        @(posedge clk);
        #1;
        if (r) begin
            sb_q.delete();
            hold_z = 32'h0;
            exp_v = 1'b0;
        end else if (sb_q.size() > 0) begin
            hold_z = sb_q.pop_front();
            exp_v = 1'b1;
        end else begin
            exp_v = 1'b0;
        end
        checks++;
        assert (out_valid === exp_v) else begin
            errors++;
            $error("FAIL %s out_valid observed %b expected %b", tag, out_valid, exp_v);
        end
        checks++;
        assert (Z === hold_z) else begin
            errors++;
            $error("FAIL %s Z observed %h expected %h", tag, Z, hold_z);
        end
    endtask

    initial begin
        logic [31:0] rx;
        logic [31:0] ry;
        step(32'h0, 32'h0, 1'b0, 1'b1, 32'h0, "reset_idle");
        step(32'hDEADBEEF, 32'h0, 1'b1, 1'b1, 32'h0, "reset_over_valid");
        step(32'hFFFFFFFF, 32'h10, 1'b1, 1'b0, 32'h0000FFFF, "shift16");
        step(32'hAAAAAAAA, 32'h1, 1'b1, 1'b0, 32'h55555555, "shift1");
        step(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0, "y_all_ones");
        step(32'hFFFFFFFF, 32'hFF, 1'b1, 1'b0, 32'h0, "y_255");
        step(32'hFFFFFFFF, 32'd32, 1'b1, 1'b0, 32'h0, "y_32");
        step(32'hFFFFFFFF, 32'd31, 1'b1, 1'b0, 32'h00000001, "y_31");
        step(32'h80000001, 32'h0, 1'b1, 1'b0, 32'h80000001, "y_0");
        step(32'h80000001, 32'h4, 1'b1, 1'b0, 32'h08000000, "zero_fill");
        step(32'h12345678, 32'h8, 1'b0, 1'b0, 32'h0, "idle_hold1");
        step(32'h12345678, 32'h8, 1'b0, 1'b0, 32'h0, "idle_hold2");
        step(32'hFFFFFFFF, 32'h20000000, 1'b1, 1'b0, 32'h0, "y_bit29");
        step(32'hC3C3C3C3, 32'h2, 1'b1, 1'b0, 32'h30F0F0F0, "shift2");
        step(32'h12345678, 32'h4, 1'b1, 1'b0, 32'h01234567, "stream_a");
        step(32'hFFFF0000, 32'h8, 1'b1, 1'b1, 32'h0, "reset_mid_stream");
        step(32'hF0000000, 32'd28, 1'b1, 1'b0, 32'h0000000F, "resume");
        step(32'h0, 32'h0, 1'b0, 1'b0, 32'h0, "resume_idle");
        for (int i = 0; i < 24; i++) begin
            rx = $urandom;
            ry = (i % 4 == 0) ? $urandom : 32'($urandom_range(0, 40));
            step(rx, ry, 1'($urandom_range(0, 3) != 0), 1'b0, ref_srl(rx, ry), "random");
        end
        step(32'h0, 32'h0, 1'b0, 1'b0, 32'h0, "drain");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_right_logical_32.md
# shift_right_logical_32

Registered 32-bit logical right shifter for the ALU datapath. Shifts operand X right by the unsigned amount in Y and zero-fills from the MSB. Any shift amount of 32 or more yields zero. The result is registered once, so the block fits a single pipeline stage beside the other ALU functional units.

## Interface
- No parameters; widths fixed at 32 (constants in shared package).
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset; sampled on rising edge of clk.
- in_valid  input  1  X/Y valid this cycle; operation accepted when high.
- X  input  32  operand to shift.
- Y  input  32  shift amount, full 32-bit unsigned (not truncated to 5 bits).
- Z  output  32  registered result.
- out_valid  output  1  Z holds a result accepted the previous cycle.

## Operation
- Result function: Z = (Y >= 32) ? 32'h0 : (X >> Y[4:0]), logical (zero fill); no sign extension ever.
- Y is unsigned: 32'hFFFFFFFF is 4294967295, not -1, so the result is 0.
- Out-of-range detect: any bit of Y[31:5] set forces result 0.
- Core: 5-stage log barrel shifter on Y[4:0] (shift by 1, 2, 4, 8, 16), each stage muxed by its Y bit, all combinational. Then an overflow mask, then the output register.
- Y = 0 passes X unchanged.
- in_valid low: Z holds its previous value; out_valid deasserts next cycle.
- No back-pressure; a new operation may be accepted every cycle.

## Timing
- Latency 1 cycle: X/Y/in_valid sampled at edge N; Z/out_valid valid after edge N.
- Throughput 1 operation per cycle.
- Reset: on an edge where rst=1, Z <= 32'h0 and out_valid <= 0, overriding in_valid.
- Reset mid-stream: the operation presented in the reset cycle is discarded; the first valid result appears the cycle after the first non-reset accept.
- No combinational path from inputs to outputs.

## Structure
- Shared ALU package: DATA_W = 32, SHAMT_W = 5.
- One sub-module, srl_stage: one barrel stage, parameterised by a constant shift distance, with select input and 32-bit in/out. Instantiated 5 times in a generate loop.
- Top level holds the overflow mask and the output/valid registers.

## Test plan
- X=32'hFFFFFFFF, Y=32'h10, in_valid=1 -> next cycle Z=32'h0000FFFF, out_valid=1.
- X=32'hAAAAAAAA, Y=1 -> Z=32'h55555555.
- X=32'hFFFFFFFF with Y=32'hFFFFFFFF, then Y=32'hFF, then Y=32 -> Z=32'h0 each time. Y=31 -> Z=32'h00000001.
- X=32'h80000001, Y=0 -> Z=32'h80000001. Y=4 -> Z=32'h08000000; check zero fill, no sign extension.
- Back-to-back: operations accepted on consecutive cycles produce results on consecutive cycles. Dropping in_valid -> out_valid=0 next cycle, Z held.
- Assert rst during a valid stream -> Z=0 and out_valid=0 after that edge. Operation in the reset cycle is lost. Normal results resume one cycle after rst drops.
